// File: rtl/p4_router_dequeue_engine.sv
// Dequeue engine for the P4 router packet buffer.
// Turns {egress port, priority} requests into buffer read commands, tags each
// read with its queue id until its data returns, emits dequeue notifications,
// and keeps a per-queue complete-packet count that drives queue_empty.

package p4_router_pkg;
    localparam int NUM_QUEUES_PER_EGR_PORT     = 4;
    localparam int NUM_QUEUES_PER_EGR_PORT_LOG = $clog2(NUM_QUEUES_PER_EGR_PORT);
    localparam int DQ_LATENCY                  = 4;
endpackage

module p4_router_dequeue_engine
    import p4_router_pkg::*;
#(
    parameter int  NUM_EGR_PORTS = 4,
    parameter int  NUM_QUEUES    = NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT,
    parameter int  PKT_CNT_WIDTH = 10,
    localparam int QW            = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
    localparam int PW            = 4,
    localparam int PRIO_W        = NUM_QUEUES_PER_EGR_PORT_LOG,
    localparam int RW            = PW + PRIO_W
) (
    input  logic                  clk,
    input  logic                  aresetn,
    output logic [NUM_QUEUES-1:0] queue_empty,
    // enqueue notification monitor; tuser is one bit wider so bad ids are visible
    input  logic                  enq_tvalid,
    input  logic                  enq_tlast,
    input  logic [QW:0]           enq_tuser,
    // dequeue request slave; tdata = {egr_port, prio}
    input  logic                  dq_req_tvalid,
    output logic                  dq_req_tready,
    input  logic [RW-1:0]         dq_req_tdata,
    // buffer read command and return
    output logic                  buf_rd_en,
    output logic [QW-1:0]         buf_rd_queue,
    input  logic                  buf_rd_valid,
    input  logic                  buf_rd_last,
    // dequeue notification master (no backpressure)
    output logic                  dq_ntf_tvalid,
    output logic                  dq_ntf_tlast,
    output logic [QW-1:0]         dq_ntf_tuser,
    output logic [31:0]           dq_ntf_tdata,
    output logic [3:0]            dq_ntf_tkeep,
    output logic [3:0]            dq_ntf_tstrb,
    output logic [3:0]            dq_ntf_tid,
    output logic [3:0]            dq_ntf_tdest,
    output logic [15:0]           req_drop_count,
    output logic                  protocol_err
);

    logic [NUM_QUEUES-1:0]    queue_empty_q, queue_empty_d;
    logic [PKT_CNT_WIDTH-1:0] pkt_count_q [NUM_QUEUES];
    logic [PKT_CNT_WIDTH-1:0] pkt_count_d [NUM_QUEUES];
    logic                     buf_rd_en_q, buf_rd_en_d;
    logic [QW-1:0]            buf_rd_queue_q, buf_rd_queue_d;
    logic [DQ_LATENCY-1:0]    tag_v_q, tag_v_d;
    logic [QW-1:0]            tag_id_q [DQ_LATENCY];
    logic [QW-1:0]            tag_id_d [DQ_LATENCY];
    logic                     ntf_valid_q, ntf_valid_d;
    logic                     ntf_last_q, ntf_last_d;
    logic [QW-1:0]            ntf_user_q, ntf_user_d;
    logic [15:0]              drop_cnt_q, drop_cnt_d;
    logic                     protocol_err_q, protocol_err_d;

    logic [PW-1:0]            req_port;
    logic [PRIO_W-1:0]        req_prio;
    logic [QW-1:0]            req_queue;
    logic                     req_accept, req_port_ok, req_valid;
    logic                     tag_out_v;
    logic [QW-1:0]            tag_out_id;
    logic                     enq_bad_id;
    logic [NUM_QUEUES-1:0]    enq_inc, deq_dec;

    // Request decode: valid requests become a read command next cycle, others are counted as drops.
    always_comb begin
        req_port       = dq_req_tdata[RW-1:PRIO_W];
        req_prio       = dq_req_tdata[PRIO_W-1:0];
        req_queue      = QW'(int'(req_port) * NUM_QUEUES_PER_EGR_PORT + int'(req_prio));
        req_accept     = dq_req_tvalid & dq_req_tready;
        req_port_ok    = int'(req_port) < NUM_EGR_PORTS;
        req_valid      = req_accept & req_port_ok & ~queue_empty_q[req_queue];
        buf_rd_en_d    = req_valid;
        buf_rd_queue_d = req_valid ? req_queue : buf_rd_queue_q;
        drop_cnt_d     = drop_cnt_q;
        if (req_accept && !req_valid && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // In-flight tag pipeline: a read issued in cycle N reaches the last stage in cycle N+DQ_LATENCY,
    // the same cycle its data returns, so the notification is registered off that alignment.
    always_comb begin
        tag_v_d     = {tag_v_q[DQ_LATENCY-2:0], buf_rd_en_q};
        tag_id_d[0] = buf_rd_queue_q;
        for (int i = 1; i < DQ_LATENCY; i++) begin
            tag_id_d[i] = tag_id_q[i-1];
        end
        tag_out_v   = tag_v_q[DQ_LATENCY-1];
        tag_out_id  = tag_id_q[DQ_LATENCY-1];
        ntf_valid_d = buf_rd_valid & tag_out_v;
        ntf_last_d  = buf_rd_valid & tag_out_v & buf_rd_last;
        ntf_user_d  = tag_out_id;
    end

    // Packet accounting and sticky error: enqueue tlast increments, dequeue tlast decrements.
    always_comb begin
        enq_inc        = '0;
        deq_dec        = '0;
        enq_bad_id     = enq_tvalid & (int'(enq_tuser) >= NUM_QUEUES);
        protocol_err_d = protocol_err_q | enq_bad_id | (buf_rd_valid ^ tag_out_v);
        for (int q = 0; q < NUM_QUEUES; q++) begin
            enq_inc[q]     = enq_tvalid & enq_tlast & (int'(enq_tuser) == q);
            deq_dec[q]     = ntf_valid_q & ntf_last_q & (int'(ntf_user_q) == q);
            pkt_count_d[q] = pkt_count_q[q];
            if (enq_inc[q] && !deq_dec[q]) begin
                if (pkt_count_q[q] == '1) begin
                    protocol_err_d = 1'b1;
                end else begin
                    pkt_count_d[q] = pkt_count_q[q] + PKT_CNT_WIDTH'(1);
                end
            end else if (deq_dec[q] && !enq_inc[q]) begin
                if (pkt_count_q[q] == '0) begin
                    protocol_err_d = 1'b1;
                end else begin
                    pkt_count_d[q] = pkt_count_q[q] - PKT_CNT_WIDTH'(1);
                end
            end
            queue_empty_d[q] = (pkt_count_d[q] == '0);
        end
    end

    // State registers; reset discards all in-flight tags.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            queue_empty_q  <= '1;
            buf_rd_en_q    <= 1'b0;
            buf_rd_queue_q <= '0;
            tag_v_q        <= '0;
            ntf_valid_q    <= 1'b0;
            ntf_last_q     <= 1'b0;
            ntf_user_q     <= '0;
            drop_cnt_q     <= '0;
            protocol_err_q <= 1'b0;
            for (int q = 0; q < NUM_QUEUES; q++) pkt_count_q[q] <= '0;
            for (int i = 0; i < DQ_LATENCY; i++) tag_id_q[i] <= '0;
        end else begin
            queue_empty_q  <= queue_empty_d;
            buf_rd_en_q    <= buf_rd_en_d;
            buf_rd_queue_q <= buf_rd_queue_d;
            tag_v_q        <= tag_v_d;
            ntf_valid_q    <= ntf_valid_d;
            ntf_last_q     <= ntf_last_d;
            ntf_user_q     <= ntf_user_d;
            drop_cnt_q     <= drop_cnt_d;
            protocol_err_q <= protocol_err_d;
            for (int q = 0; q < NUM_QUEUES; q++) pkt_count_q[q] <= pkt_count_d[q];
            for (int i = 0; i < DQ_LATENCY; i++) tag_id_q[i] <= tag_id_d[i];
        end
    end

    assign dq_req_tready  = aresetn;
    assign queue_empty    = queue_empty_q;
    assign buf_rd_en      = buf_rd_en_q;
    assign buf_rd_queue   = buf_rd_queue_q;
    assign dq_ntf_tvalid  = ntf_valid_q;
    assign dq_ntf_tlast   = ntf_last_q;
    assign dq_ntf_tuser   = ntf_user_q;
    assign dq_ntf_tdata   = '0;
    assign dq_ntf_tkeep   = '1;
    assign dq_ntf_tstrb   = '1;
    assign dq_ntf_tid     = '0;
    assign dq_ntf_tdest   = '0;
    assign req_drop_count = drop_cnt_q;
    assign protocol_err   = protocol_err_q;

endmodule
